// File: rtl/board_row_fetch_if.sv
// Board row fetch bundle: mapper request, board RAM read port, committed row.
// Piece overlay signals exist only when PIECE_OVERLAY_EN is defined.
interface board_row_fetch_if #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned CELL_W  = 16,
    parameter int unsigned ADDR_W  = 8
);
    logic              i_ld_row;
    logic [7:0]        i_row_num;
    logic [ADDR_W-1:0] o_ram_addr;
    logic              o_ram_rd_en;
    logic [CELL_W-1:0] i_ram_rdata;
    logic [CELL_W-1:0] o_row [BOARD_W];
    logic              o_row_ready;
    logic              o_busy;
`ifdef PIECE_OVERLAY_EN
    logic              i_piece_valid;
    logic [3:0]        i_piece_x [4];
    logic [4:0]        i_piece_y [4];
    logic [CELL_W-1:0] i_piece_color;
`endif

    // Mapper/RAM side
    modport master (
`ifdef PIECE_OVERLAY_EN
        output i_piece_valid, i_piece_x, i_piece_y, i_piece_color,
`endif
        output i_ld_row, i_row_num, i_ram_rdata,
        input  o_ram_addr, o_ram_rd_en, o_row, o_row_ready, o_busy
    );

    // Fetch engine side
    modport slave (
`ifdef PIECE_OVERLAY_EN
        input  i_piece_valid, i_piece_x, i_piece_y, i_piece_color,
`endif
        input  i_ld_row, i_row_num, i_ram_rdata,
        output o_ram_addr, o_ram_rd_en, o_row, o_row_ready, o_busy
    );
endinterface

// File: rtl/board_row_fetch.sv
// Fetches one board row from cell RAM into a shadow buffer and commits it atomically.
// Optional PIECE_OVERLAY_EN replaces captured cells covered by the falling piece.
module board_row_fetch #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20,
    parameter int unsigned CELL_W  = 16,
    parameter int unsigned ADDR_W  = 8
) (
    input logic               Clk,
    input logic               reset,
    board_row_fetch_if.slave  bus
);
    localparam int unsigned ROW_W = 8;
    localparam int unsigned COL_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_W - 1);

    if (BOARD_W * BOARD_H > (1 << ADDR_W)) begin : g_addr_chk
        $error("board_row_fetch: BOARD_W*BOARD_H exceeds the RAM address space");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col, w_col_nxt, w_cap_idx;
    logic              r_prev_ld;
    logic [ROW_W-1:0]  r_row_q, w_row_sel;
    logic [CELL_W-1:0] r_shadow [BOARD_W];
    logic [CELL_W-1:0] r_row    [BOARD_W];
    logic              r_row_ready, r_ram_rd_en, r_busy;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic              w_start, w_blank, w_cap, w_commit, w_rd_en_nxt;
    logic [CELL_W-1:0] w_cell;

    assign w_start   = bus.i_ld_row & ~r_prev_ld;
    assign w_row_sel = w_start ? bus.i_row_num : r_row_q;
    assign w_blank   = (w_row_sel >= ROW_W'(BOARD_H));

    always_ff @(posedge Clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Any new request edge restarts the sequence, even mid-fetch
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        if (w_start) begin
            w_col_nxt   = '0;
            w_state_nxt = w_blank ? S_COMMIT : S_ISSUE;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (r_col == LAST_COL) w_state_nxt = S_DRAIN;
                    else                   w_col_nxt   = r_col + COL_W'(1);
                end
                S_DRAIN:  w_state_nxt = S_COMMIT;
                S_COMMIT: w_state_nxt = S_IDLE;
                default:  ;
            endcase
        end
    end

    // Next values of the registered outputs, aligned to the state they belong to
    always_comb begin
        w_rd_en_nxt    = (w_state_nxt == S_ISSUE);
        w_ram_addr_nxt = r_ram_addr;
        if (w_rd_en_nxt)
            w_ram_addr_nxt = ADDR_W'(w_row_sel) * ADDR_W'(BOARD_W) + ADDR_W'(w_col_nxt);
        w_commit  = (w_state_nxt == S_COMMIT);
        w_cap     = ((r_state == S_ISSUE) && (r_col != '0)) || (r_state == S_DRAIN);
        w_cap_idx = (r_state == S_DRAIN) ? LAST_COL : (r_col - COL_W'(1));
    end

`ifdef PIECE_OVERLAY_EN
    logic w_hit;
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((ROW_W'(bus.i_piece_y[k]) == r_row_q) &&
                (ROW_W'(bus.i_piece_x[k]) == ROW_W'(w_cap_idx)))
                w_hit = 1'b1;
        end
        w_cell = (bus.i_piece_valid && w_hit) ? bus.i_piece_color : bus.i_ram_rdata;
    end
`else
    assign w_cell = bus.i_ram_rdata;
`endif

    // A commit from DRAIN folds in the last cell directly; a commit straight from a request is a blank row
    always_ff @(posedge Clk) begin
        if (!reset) begin
            r_prev_ld   <= 1'b0;
            r_row_q     <= '0;
            r_ram_rd_en <= 1'b0;
            r_ram_addr  <= '0;
            r_busy      <= 1'b0;
            r_row_ready <= 1'b0;
            for (int c = 0; c < BOARD_W; c++) begin
                r_shadow[c] <= '0;
                r_row[c]    <= '0;
            end
        end else begin
            r_prev_ld   <= bus.i_ld_row;
            if (w_start) r_row_q <= bus.i_row_num;
            r_ram_rd_en <= w_rd_en_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_row_ready <= w_commit;
            for (int c = 0; c < BOARD_W; c++) begin
                if (w_cap && (w_cap_idx == COL_W'(c))) r_shadow[c] <= w_cell;
                if (w_commit) begin
                    if (w_start)               r_row[c] <= '0;
                    else if (c == BOARD_W - 1) r_row[c] <= w_cell;
                    else                       r_row[c] <= r_shadow[c];
                end
            end
        end
    end

    assign bus.o_ram_rd_en = r_ram_rd_en;
    assign bus.o_ram_addr  = r_ram_addr;
    assign bus.o_row_ready = r_row_ready;
    assign bus.o_busy      = r_busy;
    assign bus.o_row       = r_row;
endmodule
